dmem_if: RTL and testbench

Data-memory bus interface that sits directly downstream of the `mem` stage. It takes the stage's load/store request (address, write data, access size) and runs it as a multi-cycle req/ack transaction on the external data bus. It stalls the pipeline for the duration of the transaction and returns lane-extracted, sign- or zero-extended load data back to the stage. Misaligned accesses and bus errors are reported instead of being performed.

---
 rtl/dmem_if.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_if.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Data-memory bus interface behind the mem stage: it runs each load/store
// as a registered req/ack transaction and stalls the pipeline until it ends.
// Optional feature macro: DMEM_TIMEOUT_EN (abort a BUS wait after
// TIMEOUT_CYCLES cycles with no ack/err).
// Ports:
//   clk, rst (async, active-low)
//   req_read_i/req_write_i/req_addr_i/req_wdata_i/req_funct3_i : request
//   stall_o, misalign_o                : combinational status
//   rdata_o, rdata_valid_o, bus_err_o  : registered response
//   bus_req_o/we/addr/be/wdata         : registered bus drive
//   bus_ack_i/bus_rdata_i/bus_err_i    : bus response
module dmem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        req_valid;
    logic        req_ok;
    logic        req_illegal;
    logic [3:0]  req_be;
    logic [31:0] req_wdat;
    logic        accept;

    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] lane;
    logic [31:0] load_data;

    logic        tmo_hit;
    logic        bus_done;
    logic        bus_fail;

    assign req_valid = req_read_i | req_write_i;

    // Loads allow funct3 0,1,2,4,5; stores only 0,1,2.
    assign req_illegal = req_write_i ? req_funct3_i[2]
                                     : (req_funct3_i[2] & req_funct3_i[1]);

    always_comb begin
        req_ok   = 1'b0;
        req_be   = 4'b0000;
        req_wdat = req_wdata_i;
        unique case (req_funct3_i[1:0])
            2'd0: begin
                req_ok   = 1'b1;
                req_be   = 4'b0001 << req_addr_i[1:0];
                req_wdat = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                req_ok   = ~req_addr_i[0];
                req_be   = 4'b0011 << {req_addr_i[1], 1'b0};
                req_wdat = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                req_ok   = (req_addr_i[1:0] == 2'b00);
                req_be   = 4'b1111;
            end
            default: begin
                req_ok   = 1'b0;
            end
        endcase
        if (req_illegal) begin
            req_ok = 1'b0;
        end
    end

    assign accept = (state_q == IDLE) & req_valid & req_ok;

    // Gated by rst so a request held during reset shows neither flag.
    assign stall_o    = rst & ((state_q == BUS) | accept);
    assign misalign_o = rst & (state_q == IDLE) & req_valid & ~req_ok;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == BUS) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The counter reaches the limit at the end of this cycle; a
    // same-cycle ack or err takes precedence.
    assign tmo_hit = (state_q == BUS) & ~bus_ack_i & ~bus_err_i
                   & (cnt_q == LIMIT);
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    assign bus_done = bus_ack_i | bus_err_i | tmo_hit;
    assign bus_fail = bus_err_i | tmo_hit;

    // Align the addressed lane to bit 0, then extend by access type.
    always_comb begin
        lane      = bus_rdata_i >> {off_q, 3'b000};
        load_data = lane;
        unique case (f3_q)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'd0, lane[7:0]};
            3'd5:    load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_be_o      <= '0;
            bus_wdata_o   <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            bus_err_o     <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            bus_err_o     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= req_write_i;
                        bus_addr_o  <= {req_addr_i[31:2], 2'b00};
                        bus_be_o    <= req_be;
                        bus_wdata_o <= req_wdat;
                        f3_q        <= req_funct3_i;
                        off_q       <= req_addr_i[1:0];
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        bus_req_o <= 1'b0;
                        if (bus_fail) begin
                            rdata_o   <= '0;
                            bus_err_o <= 1'b1;
                        end else if (!bus_we_o) begin
                            rdata_o       <= load_data;
                            rdata_valid_o <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_if.sv
// Randomized self-checking bench for dmem_if against a transaction-level
// reference model (lane/extension rules computed arithmetically).
module tb_dmem_if;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        req_read_i;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rd = 32'h0;

    dmem_if #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_read_i    (req_read_i),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_funct3_i  (req_funct3_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .bus_err_i     (bus_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_mis(input bit wr, input logic [31:0] a,
                                 input int f3);
        bit legal;
        legal = wr ? (f3 <= 2)
                   : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        if (f3 % 4 == 1) return (a % 2) != 0;
        if (f3 % 4 == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_be(input logic [31:0] a, input int f3);
        int off;
        off = int'(a % 4);
        if (f3 % 4 == 0) return 32'(1 << off);
        if (f3 % 4 == 1) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input int f3);
        if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [31:0] w,
                                         input logic [31:0] a, input int f3);
        logic [31:0] s;
        logic [31:0] v;
        s = w >> (8 * (a % 4));
        case (f3)
            0: begin
                v = s & 32'hFF;
                if (v >= 128) v = v + 32'hFFFFFF00;
            end
            1: begin
                v = s & 32'hFFFF;
                if (v >= 32768) v = v + 32'hFFFF0000;
            end
            4: v = s & 32'hFF;
            5: v = s & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // waits: BUS cycle index carrying the ack (-1 = never acked).
    // err_at: BUS cycle index carrying bus_err_i (-1 = none).
    task automatic run_access(input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int f3, input int waits,
                              input int err_at, input logic [31:0] word);
        bit mis;
        bit ld;
        bit err;
        int endc;
        int stalls;
        int reqs;
        logic [31:0] exp_rd;
        ld  = !wr;
        mis = m_mis(wr, a, f3);
        @(negedge clk);
        req_read_i   = rd;
        req_write_i  = wr;
        req_addr_i   = a;
        req_wdata_i  = wd;
        req_funct3_i = 3'(f3);
        #1;
        chk("misalign", 32'(misalign_o), 32'(mis));
        chk("stall_c0", 32'(stall_o), 32'(!mis));
        if (mis) begin
            @(negedge clk);
            chk("mis_noreq", 32'(bus_req_o), 32'd0);
            chk("mis_nostall", 32'(stall_o), 32'd0);
            req_read_i  = 1'b0;
            req_write_i = 1'b0;
            return;
        end
        if (err_at >= 0 && (waits < 0 || err_at <= waits)) begin
            endc = err_at;
            err  = 1'b1;
        end else if (waits >= 0) begin
            endc = waits;
            err  = 1'b0;
        end else begin
            endc = TMO - 1;
            err  = 1'b1;
        end
        stalls = 1;
        reqs   = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            bus_ack_i   = 1'b0;
            bus_err_i   = 1'b0;
            bus_rdata_i = $urandom;
            if (c == 0) begin
                chk("bus_addr", bus_addr_o, a & 32'hFFFFFFFC);
                chk("bus_be", 32'(bus_be_o), m_be(a, f3));
                chk("bus_we", 32'(bus_we_o), 32'(wr));
                if (wr) chk("bus_wdata", bus_wdata_o, m_wd(wd, f3));
            end
            reqs   += int'(bus_req_o);
            stalls += int'(stall_o);
            if (c == endc) begin
                bus_ack_i   = (c == waits);
                bus_err_i   = (c == err_at);
                bus_rdata_i = word;
                break;
            end
            if (c == 63) chk("bus_budget", 32'(c), 32'(endc));
        end
        @(negedge clk);
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        exp_rd = err ? 32'h0 : (ld ? m_ld(word, a, f3) : last_rd);
        chk("resp_stall", 32'(stall_o), 32'd0);
        chk("resp_req", 32'(bus_req_o), 32'd0);
        chk("resp_valid", 32'(rdata_valid_o), 32'(ld && !err));
        chk("resp_err", 32'(bus_err_o), 32'(err));
        chk("resp_rdata", rdata_o, exp_rd);
        chk("stall_cycles", 32'(stalls), 32'(endc + 2));
        chk("req_cycles", 32'(reqs), 32'(endc + 1));
        last_rd = exp_rd;
        @(negedge clk);
        req_read_i  = 1'b0;
        req_write_i = 1'b0;
        #1;
        chk("idle_valid", 32'(rdata_valid_o), 32'd0);
        chk("idle_err", 32'(bus_err_o), 32'd0);
        chk("idle_hold", rdata_o, last_rd);
    endtask

    initial begin
        int f3s [5] = '{0, 1, 2, 4, 5};
        rst          = 1'b0;
        req_read_i   = 1'b0;
        req_write_i  = 1'b0;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        req_funct3_i = 3'd0;
        bus_ack_i    = 1'b0;
        bus_err_i    = 1'b0;
        bus_rdata_i  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_valid", 32'(rdata_valid_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        rst = 1'b1;

        run_access(1, 0, 32'h10000004, 0, 2, 0, -1, 32'hDEADBEEF);
        run_access(1, 0, 32'h00002003, 0, 0, 0, -1, 32'h80123456);
        run_access(1, 0, 32'h00002003, 0, 4, 0, -1, 32'h80123456);
        run_access(0, 1, 32'h00002002, 32'hABCD1234, 1, 3, -1, 32'h0);
        run_access(1, 0, 32'h00002001, 0, 2, 0, -1, 32'h0);
        run_access(1, 1, 32'h00002004, 32'h55AA55AA, 0, 1, -1, 32'h0);
        run_access(1, 0, 32'h00003000, 0, 1, 2, 2, 32'h12345678);
`ifdef DMEM_TIMEOUT_EN
        run_access(1, 0, 32'h00004000, 0, 2, -1, -1, 32'h0);
        run_access(1, 0, 32'h00004000, 0, 2, -1, 1, 32'h0);
        run_access(1, 0, 32'h00004002, 0, 5, TMO - 1, -1, 32'h8001FFFF);
`else
        run_access(1, 0, 32'h00004002, 0, 1, 20, -1, 32'h8001FFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            bit wr;
            int f3;
            int w;
            int e;
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? $urandom_range(0, 2) : f3s[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) f3 = $urandom_range(0, 7);
            w = $urandom_range(0, 3);
            e = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
            run_access(!wr || ($urandom_range(0, 3) == 0), wr, $urandom,
                       $urandom, f3, w, e, $urandom);
        end

        @(negedge clk);
        req_read_i   = 1'b1;
        req_addr_i   = 32'h00005000;
        req_funct3_i = 3'd2;
        repeat (2) @(negedge clk);
        req_read_i = 1'b0;
        chk("pre_rst_req", 32'(bus_req_o), 32'd1);
        req_read_i = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus_req_o), 32'd0);
        chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_mis", 32'(misalign_o), 32'd0);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        @(negedge clk);
        req_read_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack_i = 1'b0;
        chk("late_ack_valid", 32'(rdata_valid_o), 32'd0);
        chk("late_ack_req", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        chk("late_ack_valid2", 32'(rdata_valid_o), 32'd0);
        chk("late_ack_rdata", rdata_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
